// File: rtl/test_synd_gen_gray.sv
// Chase test-syndrome generator: walks all 2^TP_POS_NUM test patterns in Gray order,
// updating the odd syndromes by XOR-ing one position's alpha-power vector per accepted beat.
module test_synd_gen_gray #(
  parameter int unsigned GF_LEN     = 10,
  parameter int unsigned SYND_NUM   = 3,
  parameter int unsigned TP_POS_NUM = 2
) (
  input  logic                                 clk,
  input  logic                                 in_ctr_Arst_n,
  input  logic                                 in_ctr_start,
  input  logic                                 in_ctr_abort,
  input  logic [GF_LEN*SYND_NUM-1:0]           in_init_synd,
  input  logic [GF_LEN*SYND_NUM*TP_POS_NUM-1:0] in_alpha_pos,
  input  logic                                 in_ctr_ready,
  output logic                                 out_valid,
  output logic [GF_LEN*SYND_NUM-1:0]           out_synd,
  output logic [TP_POS_NUM-1:0]                out_tp_gray,
  output logic                                 out_last,
  output logic                                 out_busy
);

  localparam int unsigned SYN_W   = GF_LEN * SYND_NUM;
  localparam int unsigned ALPHA_W = SYN_W * TP_POS_NUM;
  localparam logic [TP_POS_NUM-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e                state_q, state_d;
  logic [TP_POS_NUM-1:0] cnt_q, cnt_d;
  logic [TP_POS_NUM-1:0] gray_q, gray_d;
  logic [SYN_W-1:0]      synd_q, synd_d;
  logic [ALPHA_W-1:0]    alpha_q, alpha_d;
  logic [TP_POS_NUM-1:0] cnt_inc;
  logic [TP_POS_NUM-1:0] flip_sel;
  logic [SYN_W-1:0]      flip_vec;
  logic                  accept;

  assign accept = (state_q == RUN) & in_ctr_ready;

  // Lowest set bit of cnt+1 selects the position whose alpha block is XOR-ed in.
  always_comb begin
    cnt_inc  = cnt_q + TP_POS_NUM'(1);
    flip_sel = cnt_inc & (~cnt_inc + TP_POS_NUM'(1));
    flip_vec = '0;
    for (int p = 0; p < int'(TP_POS_NUM); p++) begin
      if (flip_sel[p]) flip_vec = flip_vec ^ alpha_q[p*SYN_W +: SYN_W];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gray_d  = gray_q;
    synd_d  = synd_q;
    alpha_d = alpha_q;
    if (in_ctr_abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_ctr_start) begin
            synd_d  = in_init_synd;
            alpha_d = in_alpha_pos;
            cnt_d   = '0;
            gray_d  = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          if (accept) begin
            if (cnt_q == CNT_MAX) begin
              state_d = IDLE;
            end else begin
              cnt_d  = cnt_inc;
              gray_d = cnt_inc ^ (cnt_inc >> 1);
              synd_d = synd_q ^ flip_vec;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
    if (!in_ctr_Arst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gray_q  <= '0;
      synd_q  <= '0;
      alpha_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gray_q  <= gray_d;
      synd_q  <= synd_d;
      alpha_q <= alpha_d;
    end
  end

  // Outputs are pure decodes of registers, so they stay stable under backpressure.
  assign out_valid   = (state_q == RUN);
  assign out_busy    = (state_q == RUN);
  assign out_synd    = synd_q;
  assign out_tp_gray = gray_q;
  assign out_last    = (state_q == RUN) & (cnt_q == CNT_MAX);

endmodule

// File: doc/test_synd_gen_gray.md
# test_synd_gen_gray

Parametrised Chase-decoding test-syndrome generator for the BCH decoder, placed between the hard-decision syndrome calculator and the key-equation solver. It takes the hard-decision odd syndromes and the per-position alpha-power vectors of TP_POS_NUM least-reliable bits. It then emits all 2^TP_POS_NUM test-pattern syndromes in Gray-code order, one per accepted beat. Each beat differs from the previous one by XOR-ing exactly one position's alpha-power vector, using a valid/ready output handshake.

## Interface
- GF_LEN, 10: Galois-field element width in bits.
- SYND_NUM, 3: number of odd syndromes carried (S1, S3, ..., S(2*SYND_NUM-1)).
- TP_POS_NUM, 2: number of unreliable positions; the pattern count is 2^TP_POS_NUM, and TP_POS_NUM ≥ 1.
- clk  in  1  single clock, rising edge.
- in_ctr_Arst_n  in  1  asynchronous active-low reset.
- in_ctr_start  in  1  starts a codeword; sampled only in IDLE.
- in_ctr_abort  in  1  synchronous abort; returns to IDLE.
- in_init_synd  in  GF_LEN*SYND_NUM  hard-decision syndromes; lane j = S(2j+1) at [GF_LEN*(j+1)-1 : GF_LEN*j].
- in_alpha_pos  in  GF_LEN*SYND_NUM*TP_POS_NUM  alpha-power vectors; lane (p*SYND_NUM+j) = alpha^((2j+1)*loc_p) for position p.
- in_ctr_ready  in  1  downstream accepts the current beat.
- out_valid  out  1  out_synd, out_tp_gray and out_last are valid.
- out_synd  out  GF_LEN*SYND_NUM  test syndromes, packed the same way as in_init_synd.
- out_tp_gray  out  TP_POS_NUM  Gray code of the current pattern; bit p=1 means position p is flipped.
- out_last  out  1  current beat is pattern 2^TP_POS_NUM-1.
- out_busy  out  1  state is RUN.

## Operation
- States: IDLE and RUN.
- IDLE:
  - out_valid=0.
  - On in_ctr_start=1 (and in_ctr_abort=0), register in_init_synd into the syndrome accumulator and in_alpha_pos into the alpha bank.
  - Clear the binary counter cnt (TP_POS_NUM bits) and the Gray register.
  - Go to RUN.
- RUN:
  - out_valid=1; outputs come from registers only.
  - A beat is accepted when out_valid & in_ctr_ready.
  - On accept with cnt != all-ones: cnt ← cnt+1 and Gray ← (cnt+1) ^ ((cnt+1)>>1).
  - Flipped position k = index of the lowest set bit of cnt+1. Every syndrome lane j ← lane j XOR alpha lane (k*SYND_NUM+j).
  - On accept with cnt all-ones (out_last=1): go to IDLE. Accumulator and Gray register hold their values, but out_valid drops.
  - Without accept: all registers hold, so outputs stay stable while stalled.
- in_ctr_start in RUN is ignored. The input buses are sampled only on the IDLE start cycle, so upstream may change them afterwards.
- in_ctr_abort=1 in any state forces IDLE on the next edge with out_valid=0. It has priority over start and over accept.
- out_last = out_valid & (cnt == all-ones).
- All arithmetic is GF(2) XOR; there is no carry and no width growth.
- Reset (in_ctr_Arst_n=0, asynchronous): state=IDLE, cnt=0, Gray=0, accumulator=0, alpha bank=0. Therefore out_valid=0, out_synd=0, out_tp_gray=0, out_last=0, out_busy=0. Reset mid-RUN discards the codeword with no further beats.

## Timing
- Start sampled at edge n → first beat (pattern 0, out_synd = in_init_synd, out_tp_gray=0) valid after edge n.
- With in_ctr_ready held high, one pattern per cycle; 2^TP_POS_NUM consecutive valid cycles, then out_valid=0 on the following cycle.
- A new start is accepted at the earliest in the cycle after the last beat, because IDLE must be observed. Minimum codeword period is 2^TP_POS_NUM+1 cycles.
- Ready-to-next-beat latency is 1 cycle. The syndrome update is a single XOR level from registered alpha lanes through a one-hot mux by k.
- Reset deassertion is synchronised externally; the block needs no internal synchroniser.

## Test plan
- Basic sequence, GF_LEN=10, SYND_NUM=3, TP_POS_NUM=2, ready=1. Inputs: init (0x001,0x002,0x004), pos0 (0x010,0x020,0x040), pos1 (0x100,0x200,0x080). Required beats:
  - gray 00: (0x001,0x002,0x004)
  - gray 01: (0x011,0x022,0x044)
  - gray 11: (0x111,0x222,0x0C4)
  - gray 10: (0x101,0x202,0x084), out_last=1
  - then out_valid=0.
- Backpressure: same stimulus, ready low for 3 cycles on beat 2 → out_synd stays 0x111/0x222/0x0C4 and out_tp_gray stays 11 throughout the stall; the sequence completes unchanged.
- Abort: assert in_ctr_abort on beat 1 together with ready=1 → next cycle out_valid=0, out_busy=0. A subsequent start replays from gray 00 with the newly sampled init.
- Start ignored: pulse in_ctr_start with different in_init_synd during RUN → the sequence is unaffected. Start in the cycle after the last beat → new codeword begins.
- Async reset mid-RUN: drop in_ctr_Arst_n between edges → all outputs 0 immediately, before the next clock edge.
- TP_POS_NUM=3, GF_LEN=8, random vectors → 8 beats, out_tp_gray order 000,001,011,010,110,111,101,100. Each beat equals the init XOR the alpha vectors of the set Gray bits (scoreboard check).
